pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
- Parametrised pipeline stage register for the ID/EX, EX/MEM and MEM/WB boundaries; replaces fixed per-stage registers.
- Carries a control field and a data field, and adds a valid/ready handshake, a flush that inserts a bubble, and a global Pause hold.
- An optional two-entry skid buffer lets upstream ready be driven from registered state only.

Parameters:
- CTRL_W, 12: width of control field; forced to CTRL_RST on reset, flush and bubble.
- DATA_W, 72: width of data field (PC, operands, immediate, register indices).
- CTRL_RST, 0: reset/bubble value of the control field; must encode the no-op ALU op and no-branch.
- DATA_RST, 1: reset value of the data field (PC slot resets to 1).
- SKID, 1: 1 selects the two-entry skid buffer; 0 selects a single register with combinational in_ready.

Ports:
- Clk  in  1  clock, rising edge.
- Rst  in  1  asynchronous reset, active low.
- Pause  in  1  global hold: state frozen, no transfers.
- Flush  in  1  discard all held beats and emit a bubble; overrides Pause.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  stage accepts a beat this cycle.
- in_ctrl  in  CTRL_W  upstream control field.
- in_data  in  DATA_W  upstream data field.
- out_valid  out  1  downstream beat present.
- out_ready  in  1  downstream accepts.
- out_ctrl  out  CTRL_W  control field of head beat; equals CTRL_RST whenever out_valid=0.
- out_data  out  DATA_W  data field of head beat; holds last value when out_valid=0.
- occupancy  out  2  beats held (0..2).

Behaviour:
- Reset (Rst=0, async): out_valid=0, out_ctrl=CTRL_RST, out_data=DATA_RST, skid entry empty, occupancy=0, in_ready=0. in_ready rises in the first cycle after Rst deasserts.
- Transfer conditions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready & !Pause & !Flush.
- Priority, highest first: Rst, Flush, Pause, normal operation.
- Flush (sampled at the clock edge):
  - next state EMPTY: out_valid=0, out_ctrl=CTRL_RST, skid cleared, out_data unchanged.
  - in_ready=0 during the Flush cycle, so nothing is accepted.
- Pause=1 and Flush=0: every register holds; in_ready=0; out_ready is ignored; out_valid, out_ctrl and out_data stay stable.
- SKID=1 state machine (main register plus skid register):
  - in_ready = (state != TWO) & !Pause & !Flush. No combinational path from out_ready to in_ready.
  - EMPTY: in_fire loads main and goes to ONE.
  - ONE:
    - in_fire & out_fire: main <= in, stay in ONE.
    - in_fire only: skid <= in, go to TWO.
    - out_fire only: go to EMPTY and set out_ctrl <= CTRL_RST.
  - TWO: out_fire moves skid to main and goes to ONE. in_fire is impossible.
- SKID=0:
  - in_ready = (!out_valid | out_ready) & !Pause & !Flush.
  - Single register; TWO is unreachable; occupancy never exceeds 1.
- Common to both modes:
  - Latency 1 cycle from in_fire to out_valid.
  - Sustained throughput 1 beat/cycle with out_ready held high.
  - Strict FIFO order; no beat is duplicated or dropped except by Flush.
- occupancy: EMPTY=0, ONE=1, TWO=2, updated on the same edge as the state.
- Flush and in_valid in the same cycle: the beat is not accepted; upstream holds it (upstream is normally flushed too).

Decomposition:
- Shared package pipe_pkg:
  - state encoding ST_EMPTY=2'd0, ST_ONE=2'd1, ST_TWO=2'd2;
  - per-boundary widths ID_EX_CTRL_W and ID_EX_DATA_W;
  - field offset constants for packing/unpacking;
  - no_alu_op and NB encodings used to build CTRL_RST.
- One sub-module: pipe_skid_ctrl, holding the FSM and in_ready/out_valid/occupancy with no payload. The top level instantiates it, plus main and skid payload registers gated by its load enables.

Test Plan:
1. Reset sequencing: hold Rst=0 for 3 cycles, then release -> out_valid=0, out_ctrl=0, out_data=1, occupancy=0; in_ready=1 on the first cycle after release.
2. Streaming: in_valid=1 with data 0x10, 0x11, 0x12..., out_ready=1 -> out_data follows one cycle later, in order, 1 beat/cycle; occupancy stays 1.
3. Backpressure (SKID=1): drop out_ready for 2 cycles while streaming -> occupancy reaches 2 and in_ready falls. On re-assert, beats arrive in order with none lost, and in_ready returns 1 one cycle later.
4. Pause: with occupancy=2, assert Pause for 4 cycles while toggling out_ready -> outputs and occupancy frozen, in_ready=0; the stream resumes unchanged afterwards.
5. Flush: with occupancy=2 and Pause=1, assert Flush for 1 cycle -> next cycle out_valid=0, out_ctrl=CTRL_RST, occupancy=0; in_ready=0 during the Flush cycle.
6. Reset mid-operation: assert Rst at occupancy=2 -> outputs take reset values immediately, without waiting for Clk. Repeat scenario 3 with SKID=0 -> in_ready tracks out_ready combinationally; occupancy never exceeds 1.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline boundary registers: FSM state encoding,
// per-boundary widths, control/data field offsets and bubble encodings.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  localparam int unsigned ID_EX_CTRL_W = 12;
  localparam int unsigned ID_EX_DATA_W = 72;

  // Control field layout: ALU op in the low nibble, branch kind above it.
  localparam int unsigned CTRL_ALU_LSB = 0;
  localparam int unsigned CTRL_ALU_W   = 4;
  localparam int unsigned CTRL_BR_LSB  = 4;
  localparam int unsigned CTRL_BR_W    = 3;

  // Data field layout: PC occupies the lowest slot.
  localparam int unsigned DATA_PC_LSB  = 0;

  localparam logic [CTRL_ALU_W-1:0] NO_ALU_OP = '0;
  localparam logic [CTRL_BR_W-1:0]  NB        = '0;

  function automatic logic [ID_EX_CTRL_W-1:0] ctrl_bubble();
    logic [ID_EX_CTRL_W-1:0] c;
    c = '0;
    c[CTRL_ALU_LSB +: CTRL_ALU_W] = NO_ALU_OP;
    c[CTRL_BR_LSB +: CTRL_BR_W]   = NB;
    return c;
  endfunction

  localparam logic [ID_EX_CTRL_W-1:0] ID_EX_CTRL_RST = ctrl_bubble();
  localparam logic [ID_EX_DATA_W-1:0] ID_EX_DATA_RST = ID_EX_DATA_W'(1) << DATA_PC_LSB;

endpackage

// File: rtl/pipe_skid_ctrl.sv
// Handshake FSM for a pipeline stage: tracks held beats and issues payload
// load enables; carries no payload itself.
module pipe_skid_ctrl
  import pipe_pkg::*;
#(
  parameter bit SKID = 1'b1
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Pause,
  input  logic       Flush,
  input  logic       in_valid,
  input  logic       out_ready,
  output logic       in_ready,
  output logic       out_valid,
  output logic [1:0] occupancy,
  output logic       load_main_c,
  output logic       load_skid_c,
  output logic       move_skid_c,
  output logic       clr_main_c
);

  state_e state_q, state_d;
  logic   ready_ok;
  logic   in_fire;
  logic   out_fire;

  // Skid mode decides ready from state alone; bypass mode looks at out_ready.
  assign ready_ok  = SKID ? (state_q != ST_TWO) : (!out_valid || out_ready);
  assign in_ready  = Rst && ready_ok && !Pause && !Flush;
  assign out_valid = (state_q != ST_EMPTY);
  assign occupancy = state_q;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready && !Pause && !Flush;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state_q <= ST_EMPTY;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    load_main_c = 1'b0;
    load_skid_c = 1'b0;
    move_skid_c = 1'b0;
    clr_main_c  = 1'b0;
    if (Flush) begin
      state_d    = ST_EMPTY;
      clr_main_c = 1'b1;
    end else if (!Pause) begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            load_main_c = 1'b1;
            state_d     = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            load_main_c = 1'b1;
          end else if (in_fire) begin
            load_skid_c = 1'b1;
            state_d     = ST_TWO;
          end else if (out_fire) begin
            clr_main_c  = 1'b1;
            state_d     = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (out_fire) begin
            move_skid_c = 1'b1;
            state_d     = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Parametrised pipeline boundary register with valid/ready handshake, flush
// bubble, global pause and optional two-entry skid buffer.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned       CTRL_W   = ID_EX_CTRL_W,
  parameter int unsigned       DATA_W   = ID_EX_DATA_W,
  parameter logic [CTRL_W-1:0] CTRL_RST = CTRL_W'(ID_EX_CTRL_RST),
  parameter logic [DATA_W-1:0] DATA_RST = DATA_W'(ID_EX_DATA_RST),
  parameter bit                SKID     = 1'b1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Pause,
  input  logic              Flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic              load_main_c;
  logic              load_skid_c;
  logic              move_skid_c;
  logic              clr_main_c;
  logic [CTRL_W-1:0] main_ctrl_q;
  logic [DATA_W-1:0] main_data_q;
  logic [CTRL_W-1:0] skid_ctrl_q;
  logic [DATA_W-1:0] skid_data_q;

  pipe_skid_ctrl #(
    .SKID (SKID)
  ) u_ctrl (
    .Clk         (Clk),
    .Rst         (Rst),
    .Pause       (Pause),
    .Flush       (Flush),
    .in_valid    (in_valid),
    .out_ready   (out_ready),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .occupancy   (occupancy),
    .load_main_c (load_main_c),
    .load_skid_c (load_skid_c),
    .move_skid_c (move_skid_c),
    .clr_main_c  (clr_main_c)
  );

  // Head register: control drops to the bubble value whenever it empties,
  // data keeps its last value.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      main_ctrl_q <= CTRL_RST;
      main_data_q <= DATA_RST;
    end else if (clr_main_c) begin
      main_ctrl_q <= CTRL_RST;
    end else if (load_main_c) begin
      main_ctrl_q <= in_ctrl;
      main_data_q <= in_data;
    end else if (move_skid_c) begin
      main_ctrl_q <= skid_ctrl_q;
      main_data_q <= skid_data_q;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      skid_ctrl_q <= CTRL_RST;
      skid_data_q <= '0;
    end else if (load_skid_c) begin
      skid_ctrl_q <= in_ctrl;
      skid_data_q <= in_data;
    end
  end

  assign out_ctrl = main_ctrl_q;
  assign out_data = main_data_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: SKID=1 and SKID=0 instances share stimulus and
// are each compared every cycle against a queue-based reference.
module tb_pipe_stage_skid;

  typedef struct packed {
    logic [11:0] c;
    logic [71:0] d;
  } beat_t;

  logic        Clk = 1'b0;
  logic        Rst, Pause, Flush, in_valid, out_ready;
  logic [11:0] in_ctrl;
  logic [71:0] in_data;

  logic        in_ready1, out_valid1, in_ready0, out_valid0;
  logic [11:0] out_ctrl1, out_ctrl0;
  logic [71:0] out_data1, out_data0;
  logic [1:0]  occupancy1, occupancy0;

  beat_t       q1[$];
  beat_t       q0[$];
  logic [71:0] last1, last0;
  int          seq;
  bit          adv;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 Clk = ~Clk;

  pipe_stage_skid #(.SKID(1'b1)) dut1 (
    .Clk(Clk), .Rst(Rst), .Pause(Pause), .Flush(Flush),
    .in_valid(in_valid), .in_ready(in_ready1), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_ctrl(out_ctrl1),
    .out_data(out_data1), .occupancy(occupancy1)
  );

  pipe_stage_skid #(.SKID(1'b0)) dut0 (
    .Clk(Clk), .Rst(Rst), .Pause(Pause), .Flush(Flush),
    .in_valid(in_valid), .in_ready(in_ready0), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_ctrl(out_ctrl0),
    .out_data(out_data0), .occupancy(occupancy0)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference acceptance rule: capacity 2 with skid, else pass-through when drained.
  function automatic logic exp_ready(input bit skid, input int sz);
    return Rst && !Pause && !Flush && (skid ? (sz < 2) : (sz == 0 || out_ready));
  endfunction

  task automatic check_all();
    chk("in_ready1",  in_ready1,  exp_ready(1'b1, q1.size()));
    chk("out_valid1", out_valid1, q1.size() != 0);
    chk("out_ctrl1",  out_ctrl1,  q1.size() != 0 ? q1[0].c : 12'h000);
    chk("out_data1",  out_data1,  q1.size() != 0 ? q1[0].d : last1);
    chk("occupancy1", occupancy1, q1.size());
    chk("in_ready0",  in_ready0,  exp_ready(1'b0, q0.size()));
    chk("out_valid0", out_valid0, q0.size() != 0);
    chk("out_ctrl0",  out_ctrl0,  q0.size() != 0 ? q0[0].c : 12'h000);
    chk("out_data0",  out_data0,  q0.size() != 0 ? q0[0].d : last0);
    chk("occupancy0", occupancy0, q0.size());
  endtask

  task automatic model_reset();
    q1.delete();
    q0.delete();
    last1 = 72'd1;
    last0 = 72'd1;
  endtask

  task automatic model_step();
    bit    f1, f0;
    beat_t b;
    adv = 1'b0;
    if (!Rst) begin
      model_reset();
      return;
    end
    if (Flush) begin
      q1.delete();
      q0.delete();
      return;
    end
    if (Pause) return;
    f1 = in_valid && exp_ready(1'b1, q1.size());
    f0 = in_valid && exp_ready(1'b0, q0.size());
    b.c = in_ctrl;
    b.d = in_data;
    if (q1.size() != 0 && out_ready) void'(q1.pop_front());
    if (f1) q1.push_back(b);
    if (q1.size() != 0) last1 = q1[0].d;
    if (q0.size() != 0 && out_ready) void'(q0.pop_front());
    if (f0) q0.push_back(b);
    if (q0.size() != 0) last0 = q0[0].d;
    adv = f1;
  endtask

  // Check at negedge, advance the model, then present the next beat after the edge.
  task automatic cycle();
    @(negedge Clk);
    check_all();
    model_step();
    @(posedge Clk);
    #1;
    if (adv) begin
      seq++;
      in_data = 72'(seq);
      in_ctrl = 12'($urandom);
    end
  endtask

  initial begin
    Rst = 1'b0; Pause = 1'b0; Flush = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    seq = 16;
    in_data = 72'(seq);
    in_ctrl = 12'($urandom);
    model_reset();

    // reset held, then released away from the edge
    repeat (3) cycle();
    Rst = 1'b1;
    cycle();

    // streaming at full rate
    in_valid = 1'b1; out_ready = 1'b1;
    repeat (6) cycle();

    // backpressure
    out_ready = 1'b0;
    repeat (2) cycle();
    out_ready = 1'b1;
    repeat (4) cycle();

    // fill, then pause with out_ready toggling
    out_ready = 1'b0;
    repeat (2) cycle();
    Pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      out_ready = i[0];
      cycle();
    end

    // flush while paused
    Flush = 1'b1;
    cycle();
    Flush = 1'b0; Pause = 1'b0; out_ready = 1'b1;
    repeat (3) cycle();

    // asynchronous reset mid-operation
    out_ready = 1'b0;
    repeat (3) cycle();
    Rst = 1'b0;
    #1;
    chk("async_rst_valid1", out_valid1, 1'b0);
    chk("async_rst_occ1",   occupancy1, 2'd0);
    chk("async_rst_ctrl1",  out_ctrl1,  12'h000);
    chk("async_rst_data1",  out_data1,  72'd1);
    chk("async_rst_ready1", in_ready1,  1'b0);
    chk("async_rst_valid0", out_valid0, 1'b0);
    model_reset();
    repeat (2) cycle();
    Rst = 1'b1;
    cycle();

    // randomized traffic with occasional pause/flush
    repeat (400) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      Pause     = ($urandom_range(0, 15) == 0);
      Flush     = ($urandom_range(0, 31) == 0);
      cycle();
    end

    Pause = 1'b0; Flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
